// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot controller.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN3 = 3'd1,
        SPIN2 = 3'd2,
        SPIN1 = 3'd3,
        JUDGE = 3'd4,
        SHOW  = 3'd5
    } slot_state_t;

    localparam logic [1:0] WIN_NONE    = 2'd0;
    localparam logic [1:0] WIN_PAIR    = 2'd1;
    localparam logic [1:0] WIN_TRIPLE  = 2'd2;
    localparam logic [1:0] WIN_JACKPOT = 2'd3;

    localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/slot_win_eval.sv
// Combinational scoring of three stopped reel digits; any illegal digit voids the win.
module slot_win_eval
    import slot_pkg::*;
(
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] jackpot_digit,
    output logic [1:0] win_code
);

    logic any_illegal;
    logic all_equal;
    logic some_equal;

    always_comb begin
        any_illegal = (digit0 > MAX_DIGIT) || (digit1 > MAX_DIGIT) || (digit2 > MAX_DIGIT);
        all_equal   = (digit0 == digit1) && (digit1 == digit2);
        some_equal  = (digit0 == digit1) || (digit1 == digit2) || (digit0 == digit2);

        win_code = WIN_NONE;
        if (any_illegal) begin
            win_code = WIN_NONE;
        end else if (all_equal) begin
            win_code = (digit0 == jackpot_digit) ? WIN_JACKPOT : WIN_TRIPLE;
        end else if (some_equal) begin
            win_code = WIN_PAIR;
        end
    end

endmodule

// File: rtl/slot_reel_ctrl.sv
// Three-reel slot sequencer: start spins all reels, rate-limited stops freeze them
// left to right, then the result is scored once and displayed until the next start.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, all reels paused, waiting for i_start
// SPIN3 | all three reels spinning, next stop freezes reel 0
// SPIN2 | reel 0 frozen, next stop freezes reel 1
// SPIN1 | reels 0-1 frozen, next stop freezes reel 2
// JUDGE | single cycle, o_win registered from latched results
// SHOW  | result displayed with o_done, i_start begins a new spin
module slot_reel_ctrl
    import slot_pkg::*;
#(
    parameter int         STOP_GAP      = 4,
    parameter logic [3:0] JACKPOT_DIGIT = 4'd7
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [3:0] i_reel0,
    input  logic [3:0] i_reel1,
    input  logic [3:0] i_reel2,
    output logic [2:0] o_pause,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_result0,
    output logic [3:0] o_result1,
    output logic [3:0] o_result2,
    output logic [1:0] o_win
);

    localparam logic [7:0] GAP_LOAD = 8'(STOP_GAP);

    slot_state_t state_q;
    slot_state_t state_d;
    logic [7:0]  gap_q;
    logic        stop_ok;
    logic        clear_game;
    logic [2:0]  latch_reel;
    logic        load_win;
    logic [1:0]  win_comb;

    assign stop_ok = i_stop && (gap_q == 8'd0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clear_game = 1'b0;
        latch_reel = 3'b000;
        load_win   = 1'b0;
        o_pause    = 3'b111;
        o_busy     = 1'b0;
        o_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = SPIN3;
                    clear_game = 1'b1;
                end
            end
            SPIN3: begin
                o_pause = 3'b000;
                o_busy  = 1'b1;
                if (stop_ok) begin
                    latch_reel = 3'b001;
                    state_d    = SPIN2;
                end
            end
            SPIN2: begin
                o_pause = 3'b001;
                o_busy  = 1'b1;
                if (stop_ok) begin
                    latch_reel = 3'b010;
                    state_d    = SPIN1;
                end
            end
            SPIN1: begin
                o_pause = 3'b011;
                o_busy  = 1'b1;
                if (stop_ok) begin
                    latch_reel = 3'b100;
                    state_d    = JUDGE;
                end
            end
            JUDGE: begin
                load_win = 1'b1;
                state_d  = SHOW;
            end
            SHOW: begin
                o_done = 1'b1;
                // start beats a simultaneous stop here; the stop is simply dropped
                if (i_start) begin
                    state_d    = SPIN3;
                    clear_game = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stop-spacing down-counter; every accepted stop or new spin re-arms it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            gap_q <= 8'd0;
        end else if (clear_game || (latch_reel != 3'b000)) begin
            gap_q <= GAP_LOAD;
        end else if (gap_q != 8'd0) begin
            gap_q <= gap_q - 8'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_result0 <= 4'd0;
            o_result1 <= 4'd0;
            o_result2 <= 4'd0;
            o_win     <= WIN_NONE;
        end else if (clear_game) begin
            o_result0 <= 4'd0;
            o_result1 <= 4'd0;
            o_result2 <= 4'd0;
            o_win     <= WIN_NONE;
        end else begin
            if (latch_reel[0]) o_result0 <= i_reel0;
            if (latch_reel[1]) o_result1 <= i_reel1;
            if (latch_reel[2]) o_result2 <= i_reel2;
            if (load_win)      o_win     <= win_comb;
        end
    end

    slot_win_eval u_win_eval (
        .digit0        (o_result0),
        .digit1        (o_result1),
        .digit2        (o_result2),
        .jackpot_digit (JACKPOT_DIGIT),
        .win_code      (win_comb)
    );

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Scoreboard bench for slot_reel_ctrl: games push expected results, a monitor
// compares them on each rising o_done; directed checks cover timing and reset.
module tb_slot_reel_ctrl;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] reel0, reel1, reel2;
    logic [2:0] o_pause;
    logic       o_busy, o_done;
    logic [3:0] o_result0, o_result1, o_result2;
    logic [1:0] o_win;

    typedef struct packed {
        logic [3:0] r0;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [1:0] win;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic done_prev = 1'b0;

    slot_reel_ctrl #(
        .STOP_GAP      (GAP),
        .JACKPOT_DIGIT (4'd7)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_reel0   (reel0),
        .i_reel1   (reel1),
        .i_reel2   (reel2),
        .o_pause   (o_pause),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_result0 (o_result0),
        .o_result1 (o_result1),
        .o_result2 (o_result2),
        .o_win     (o_win)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each new displayed result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (o_done && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 expected no result pending (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result0", o_result0, e.r0);
                check("sb_result1", o_result1, e.r1);
                check("sb_result2", o_result2, e.r2);
                check("sb_win",     o_win,     e.win);
            end
        end
        done_prev = o_done;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_result(input logic [3:0] r0, input logic [3:0] r1,
                                 input logic [3:0] r2, input logic [1:0] w);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.r2 = r2; e.win = w;
        sb_q.push_back(e);
    endtask

    // Leaves the bench at the negedge of the first SPIN3 cycle (gap counter = GAP).
    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Presents digit d on the target reel and a different digit on the others.
    task automatic do_stop(input int reel, input logic [3:0] d);
        logic [3:0] f;
        f = (d == 4'd9) ? 4'd0 : d + 4'd1;
        reel0 = (reel == 0) ? d : f;
        reel1 = (reel == 1) ? d : f;
        reel2 = (reel == 2) ? d : f;
        stop  = 1'b1;
        cyc(1);
        stop  = 1'b0;
    endtask

    task automatic play(input logic [3:0] r0, input logic [3:0] r1,
                        input logic [3:0] r2, input logic [1:0] w);
        expect_result(r0, r1, r2, w);
        do_start();
        check("spin3_pause", o_pause, 3'b000);
        cyc(GAP);
        do_stop(0, r0);
        check("pause_after_stop0", o_pause, 3'b001);
        cyc(GAP);
        do_stop(1, r1);
        check("pause_after_stop1", o_pause, 3'b011);
        cyc(GAP);
        do_stop(2, r2);
        check("judge_pause", o_pause, 3'b111);
        check("judge_busy",  o_busy,  1'b0);
        check("judge_done",  o_done,  1'b0);
        cyc(1);
        check("done_latency", o_done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        reel0 = 4'd0; reel1 = 4'd0; reel2 = 4'd0;
        cyc(2);
        check("rst_pause",   o_pause,   3'b111);
        check("rst_busy",    o_busy,    1'b0);
        check("rst_done",    o_done,    1'b0);
        check("rst_result0", o_result0, 4'd0);
        check("rst_win",     o_win,     2'd0);
        rst = 1'b0;
        cyc(2);

        do_stop(0, 4'd5);
        check("idle_stop_pause", o_pause, 3'b111);
        check("idle_stop_busy",  o_busy,  1'b0);

        play(4'd3, 4'd5, 4'd8, 2'd0);
        play(4'd7, 4'd7, 4'd7, 2'd3);
        play(4'd4, 4'd4, 4'd4, 2'd2);
        play(4'd2, 4'd9, 4'd2, 2'd1);
        play(4'd1, 4'd6, 4'd6, 2'd1);
        play(4'd0, 4'd0, 4'd5, 2'd1);
        play(4'd6, 4'hF, 4'd6, 2'd0);

        // Stop spacing: too-early stops are dropped, not queued.
        expect_result(4'd8, 4'd2, 4'd8, 2'd1);
        do_start();
        cyc(2);
        do_stop(0, 4'd1);
        check("early_stop_pause", o_pause, 3'b000);
        check("early_stop_busy",  o_busy,  1'b1);
        cyc(1);
        do_stop(0, 4'd8);
        check("gap_stop_pause", o_pause, 3'b001);
        cyc(GAP - 1);
        do_stop(1, 4'd5);
        check("reload_stop_pause", o_pause, 3'b001);
        do_stop(1, 4'd2);
        check("reload_ok_pause", o_pause, 3'b011);
        cyc(GAP);
        do_stop(2, 4'd8);
        cyc(1);
        check("gap_game_done", o_done, 1'b1);

        // Start ignored while spinning/judging; start+stop in SHOW restarts.
        expect_result(4'd9, 4'd3, 4'd0, 2'd0);
        do_start();
        cyc(GAP);
        do_stop(0, 4'd9);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("spin2_start_pause",   o_pause,   3'b001);
        check("spin2_start_busy",    o_busy,    1'b1);
        check("spin2_start_result0", o_result0, 4'd9);
        cyc(GAP - 1);
        do_stop(1, 4'd3);
        cyc(GAP);
        do_stop(2, 4'd0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("judge_start_done", o_done, 1'b1);
        cyc(2);
        expect_result(4'd2, 4'd2, 4'd2, 2'd2);
        reel0 = 4'd5;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("show_restart_pause",   o_pause,   3'b000);
        check("show_restart_busy",    o_busy,    1'b1);
        check("show_restart_done",    o_done,    1'b0);
        check("show_restart_result0", o_result0, 4'd0);
        check("show_restart_result1", o_result1, 4'd0);
        check("show_restart_win",     o_win,     2'd0);
        cyc(GAP);
        do_stop(0, 4'd2);
        cyc(GAP);
        do_stop(1, 4'd2);
        cyc(GAP);
        do_stop(2, 4'd2);
        cyc(1);
        check("restart_game_done", o_done, 1'b1);

        // Asynchronous reset in SPIN1 abandons the game.
        do_start();
        cyc(GAP);
        do_stop(0, 4'd1);
        cyc(GAP);
        do_stop(1, 4'd2);
        check("pre_reset_pause", o_pause, 3'b011);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pause",   o_pause,   3'b111);
        check("async_rst_busy",    o_busy,    1'b0);
        check("async_rst_done",    o_done,    1'b0);
        check("async_rst_result0", o_result0, 4'd0);
        check("async_rst_result1", o_result1, 4'd0);
        check("async_rst_win",     o_win,     2'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            do_stop(2, 4'd3);
            check("post_rst_stop_pause", o_pause, 3'b111);
            check("post_rst_stop_busy",  o_busy,  1'b0);
        end

        play(4'd3, 4'd3, 4'd7, 2'd1);

        cyc(3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
